// File: rtl/mul4_pkg.sv
// mul4_pkg -- shared definitions for the sequential shift-and-add multiplier.
//
// Contents:
//   MUL4_W_DEF    default operand width in bits
//   mul4_state_t  controller state encoding (IDLE, CALC, DONE)
//   mul4_cnt_w()  width of the iteration counter for a given operand width
package mul4_pkg;

  localparam int MUL4_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul4_state_t;

  // The counter only has to hold 0..W-1; it is allowed to wrap on the
  // final CALC edge because it is cleared again on every accept.
  function automatic int mul4_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/add_stage.sv
// add_stage -- W-bit unsigned adder with carry-out.
//
// Ports:
//   x, y  [W-1:0]  addends
//   sum   [W-1:0]  low W bits of x + y
//   cout           carry out of bit W-1
module add_stage #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum,
  output logic         cout
);

  always_comb begin
    {cout, sum} = {1'b0, x} + {1'b0, y};
  end

endmodule

// File: rtl/mul_4b_seq.sv
// mul_4b_seq -- sequential unsigned multiplier (shift-and-add, one bit per cycle).
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair a/b present
//   in_ready   block can accept operands (high only in IDLE)
//   a [W-1:0]  multiplicand, unsigned
//   b [W-1:0]  multiplier, unsigned
//   out_valid  product p valid (high only in DONE)
//   out_ready  consumer takes p
//   p [2W-1:0] unsigned product a*b
//
// Build option:
//   MUL4_ZERO_SKIP_EN  when defined, an operation with a==0 or b==0 goes
//                      straight from IDLE to DONE with p=0.
//
// State table:
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   CALC  | one shift-and-add step per edge, W edges in total
//   DONE  | product on p, out_valid=1, held until out_ready
module mul_4b_seq
  import mul4_pkg::*;
#(
  parameter int W = MUL4_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam int CW = mul4_cnt_w(W);

  mul4_state_t state, state_nx;

  logic [W-1:0]  mcand;
  logic [W-1:0]  acc;
  logic [W-1:0]  mplr;
  logic [CW-1:0] cnt;

  logic [W-1:0]  addend;
  logic [W-1:0]  sum;
  logic          cout;
  logic          last_iter;
  logic          zero_op;

`ifdef MUL4_ZERO_SKIP_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign last_iter = (cnt == CW'(W - 1));
  assign addend    = mplr[0] ? mcand : '0;

  add_stage #(.W(W)) u_add (
    .x    (acc),
    .y    (addend),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = zero_op ? DONE : CALC;
      CALC:    if (last_iter) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The multiplier register doubles as the low half of the product: each
  // CALC edge shifts one multiplier bit out and one product bit in, so after
  // W edges {acc, mplr} is the full product and no separate output copy is
  // needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= a;
            acc   <= '0;
            mplr  <= zero_op ? '0 : b;
            cnt   <= '0;
          end
        end
        CALC: begin
          acc  <= {cout, sum[W-1:1]};
          mplr <= {sum[0], mplr[W-1:1]};
          cnt  <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign p         = {acc, mplr};

endmodule

// File: doc/mul_4b_seq.md
MUL_4B_SEQ -- requirements
Module: mul_4b_seq

Interface
REQ-001 Parameter W, default 4: operand width in bits; product width is 2*W.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous, active-high.
REQ-004 Port in_valid, input, 1: operand pair a/b present.
REQ-005 Port in_ready, output, 1: block can accept operands.
REQ-006 Port a, input, W: multiplicand, unsigned.
REQ-007 Port b, input, W: multiplier, unsigned.
REQ-008 Port out_valid, output, 1: product p valid.
REQ-009 Port out_ready, input, 1: consumer takes p.
REQ-010 Port p, output, 2*W: unsigned product a*b.

Function
REQ-011 The block SHALL implement a shift-and-add FSM with states IDLE, CALC, DONE.
REQ-012 In IDLE: in_ready=1 and out_valid=0; in all other states in_ready=0.
REQ-013 Accept: an edge with in_valid=1 and in_ready=1 SHALL latch a and b, clear the accumulator and the iteration counter, and move to CALC.
REQ-014 Each CALC edge: if the multiplier LSB is 1, add the multiplicand to the upper W accumulator bits using a W-bit add with carry-out; otherwise add 0. Then shift {carry, accumulator, multiplier} right by one and increment the counter.
REQ-015 After exactly W CALC edges the FSM SHALL enter DONE; out_valid rises W cycles after the accepting edge.
REQ-016 In DONE: out_valid=1 and p holds the exact 2*W-bit product, stable until the handshake completes; no overflow is possible.
REQ-017 An edge with out_valid=1 and out_ready=1 SHALL return the FSM to IDLE; out_valid drops on the next cycle.
REQ-018 The block SHALL NOT go from DONE directly back into CALC; accept and release take separate cycles.
REQ-019 in_valid, a and b SHALL be ignored outside IDLE; input changes during CALC/DONE do not affect p.
REQ-020 out_ready SHALL be ignored outside DONE.
REQ-021 Operands 0 or 2^W-1 SHALL follow the same W-cycle timing unless REQ-026 applies.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, p=0, out_valid=0, in_ready=1, counter=0, accumulator=0, and discard any operation in progress.
REQ-023 If rst and in_valid are both 1 at the same edge, rst SHALL win and the operands SHALL NOT be accepted.

Configuration
REQ-024 The macro MUL4_ZERO_SKIP_EN SHALL control the zero-operand fast path.
REQ-025 Without MUL4_ZERO_SKIP_EN, every accepted operation SHALL take exactly W CALC cycles.
REQ-026 With MUL4_ZERO_SKIP_EN, an accepted operation with a==0 or b==0 SHALL go directly from IDLE to DONE with p=0, so out_valid rises 1 cycle after the accepting edge.

Structure
REQ-027 A shared package mul4_pkg SHALL hold the state enum (IDLE, CALC, DONE) and the default width constant.
REQ-028 The W-bit add with carry-out SHALL be a separate sub-module, add_stage (inputs x, y; outputs sum, cout), used once per CALC cycle.
REQ-029 All outputs SHALL be driven from registers or directly from the state register; there SHALL be no combinational path from in_valid or out_ready to any output.

Verification
REQ-030 Basic: a=3, b=5, accepted at edge 0 -> out_valid=1 after edge 4, p=8'd15, in_ready=0 during edges 1-4.
REQ-031 Max: a=15, b=15 -> p=8'd225 after 4 CALC cycles; a=15, b=1 -> p=8'd15.
REQ-032 Backpressure: a=7, b=6 with out_ready=0 for 5 cycles after out_valid rises -> p holds 8'd42, in_ready stays 0; out_ready=1 -> IDLE on the next edge, in_ready=1.
REQ-033 Zero: a=0, b=9 -> p=0 after 4 cycles without MUL4_ZERO_SKIP_EN and after 1 cycle with it.
REQ-034 Reset mid-op: a=9, b=9 accepted, then rst=1 after 2 CALC edges -> next cycle IDLE, p=0, out_valid=0; a new operation a=2, b=3 gives p=8'd6.
REQ-035 Exhaustive: all 256 pairs of a and b, applied back-to-back with out_ready=1 -> each p matches a*b; throughput is one result per W+2 cycles.
